// File: rtl/kplic_claim_master_pkg.sv
// Shared encodings for the KPLIC claim/complete bus master.
// Holds the AHB-Lite encodings used by the initiator, the KPLIC register
// defaults, and the claim sequencer state type.
package kplic_claim_master_pkg;

    // KPLIC register map and interrupt ID width
    localparam logic [31:0] KPLIC_CLAIM_ADDR = 32'h0000_0204;
    localparam int          KPLIC_ID_WIDTH   = 5;

    // AHB-Lite widths and encodings
    localparam int          AHB_ADDR_WIDTH   = 32;
    localparam int          AHB_DATA_WIDTH   = 32;
    localparam logic [1:0]  HTRANS_IDLE      = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ    = 2'b10;
    localparam logic [2:0]  HSIZE_WORD       = 3'b010;
    localparam logic [2:0]  HBURST_SINGLE    = 3'b000;
    localparam logic [1:0]  HRESP_ERROR      = 2'b01;

    // Claim / present / complete sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_C_ADDR  = 3'd1,
        ST_C_DATA  = 3'd2,
        ST_PRESENT = 3'd3,
        ST_ACTIVE  = 3'd4,
        ST_W_ADDR  = 3'd5,
        ST_W_DATA  = 3'd6
    } claim_state_t;

    // A completed data phase is an error only for the ERROR response code
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp == HRESP_ERROR;
    endfunction

endpackage

// File: rtl/kplic_claim_master.sv
// Core-side AHB-Lite master: claims an interrupt ID from KPLIC on kplic_int,
// hands it to the core over irq_valid/irq_ready, then writes it back on irq_done.
// Optional KPLIC_CLAIM_SPURIOUS_CNT_EN builds a saturating counter of ID-0 claims.
module kplic_claim_master
    import kplic_claim_master_pkg::*;
#(
    parameter int                    ADDR_WIDTH = AHB_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = AHB_DATA_WIDTH,
    parameter int                    ID_WIDTH   = KPLIC_ID_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] CLAIM_ADDR = ADDR_WIDTH'(KPLIC_CLAIM_ADDR)
) (
    input  logic                  kplic_clk,
    input  logic                  kplic_rst,
    input  logic                  kplic_int,
    output logic                  irq_valid,
    input  logic                  irq_ready,
    output logic [ID_WIDTH-1:0]   irq_id,
    input  logic                  irq_done,
    output logic                  bus_err,
    output logic [15:0]           spurious_cnt,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    input  logic [1:0]            HRESP,
    input  logic [DATA_WIDTH-1:0] HRDATA
);

    claim_state_t        state;
    logic [ID_WIDTH-1:0] rd_id;
    logic                unused_hrdata;

    // Only the low ID_WIDTH bits of the claim register carry the interrupt ID
    assign rd_id         = HRDATA[ID_WIDTH-1:0];
    assign unused_hrdata = ^HRDATA[DATA_WIDTH-1:ID_WIDTH];

    // Every transfer is a single word
    assign HSIZE  = HSIZE_WORD;
    assign HBURST = HBURST_SINGLE;

    // Claim/present/complete sequencer; bus and core outputs are registered here
    // so the address phase never depends combinationally on HREADY.
    always_ff @(posedge kplic_clk or posedge kplic_rst) begin
        if (kplic_rst) begin
            state     <= ST_IDLE;
            HTRANS    <= HTRANS_IDLE;
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HWDATA    <= '0;
            irq_id    <= '0;
            irq_valid <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (kplic_int) begin
                        state  <= ST_C_ADDR;
                        HTRANS <= HTRANS_NONSEQ;
                        HADDR  <= CLAIM_ADDR;
                        HWRITE <= 1'b0;
                    end
                end
                ST_C_ADDR: begin
                    if (HREADY) begin
                        state  <= ST_C_DATA;
                        HTRANS <= HTRANS_IDLE;
                    end
                end
                ST_C_DATA: begin
                    if (HREADY) begin
                        if (resp_is_err(HRESP)) begin
                            bus_err <= 1'b1;
                            state   <= ST_IDLE;
                        end else if (rd_id == '0) begin
                            // Nothing pending: spurious claim, nothing to complete
                            state <= ST_IDLE;
                        end else begin
                            irq_id    <= rd_id;
                            irq_valid <= 1'b1;
                            state     <= ST_PRESENT;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (irq_ready) begin
                        irq_valid <= 1'b0;
                        state     <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (irq_done) begin
                        state  <= ST_W_ADDR;
                        HTRANS <= HTRANS_NONSEQ;
                        HADDR  <= CLAIM_ADDR;
                        HWRITE <= 1'b1;
                        // Loaded now so it is already stable for the data phase
                        HWDATA <= {{(DATA_WIDTH-ID_WIDTH){1'b0}}, irq_id};
                    end
                end
                ST_W_ADDR: begin
                    if (HREADY) begin
                        state  <= ST_W_DATA;
                        HTRANS <= HTRANS_IDLE;
                    end
                end
                ST_W_DATA: begin
                    if (HREADY) begin
                        bus_err <= resp_is_err(HRESP);
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    HTRANS <= HTRANS_IDLE;
                end
            endcase
        end
    end

`ifdef KPLIC_CLAIM_SPURIOUS_CNT_EN
    logic spurious_hit;

    // An OKAY claim data phase that returns ID 0
    assign spurious_hit = (state == ST_C_DATA) && HREADY &&
                          !resp_is_err(HRESP) && (rd_id == '0);

    // Saturating count of spurious claims
    always_ff @(posedge kplic_clk or posedge kplic_rst) begin
        if (kplic_rst) begin
            spurious_cnt <= 16'h0;
        end else if (spurious_hit && (spurious_cnt != 16'hFFFF)) begin
            spurious_cnt <= spurious_cnt + 16'd1;
        end
    end
`else
    assign spurious_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_kplic_claim_master.sv
// Randomized bench for kplic_claim_master: acts as the AHB slave and the core,
// and predicts every bus transfer and core handshake from a transaction model.
module tb_kplic_claim_master;

    localparam logic [31:0] CLAIM    = 32'h0000_0204;
    localparam logic [1:0]  T_IDLE   = 2'b00;
    localparam logic [1:0]  T_NONSEQ = 2'b10;
    localparam logic [1:0]  R_OKAY   = 2'b00;
    localparam logic [1:0]  R_ERR    = 2'b01;

    logic        kplic_clk = 1'b0;
    logic        kplic_rst;
    logic        kplic_int;
    logic        irq_valid;
    logic        irq_ready;
    logic [4:0]  irq_id;
    logic        irq_done;
    logic        bus_err;
    logic [15:0] spurious_cnt;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [15:0] exp_spur = 16'h0;

    kplic_claim_master dut (
        .kplic_clk    (kplic_clk),
        .kplic_rst    (kplic_rst),
        .kplic_int    (kplic_int),
        .irq_valid    (irq_valid),
        .irq_ready    (irq_ready),
        .irq_id       (irq_id),
        .irq_done     (irq_done),
        .bus_err      (bus_err),
        .spurious_cnt (spurious_cnt),
        .HADDR        (HADDR),
        .HTRANS       (HTRANS),
        .HWRITE       (HWRITE),
        .HSIZE        (HSIZE),
        .HBURST       (HBURST),
        .HWDATA       (HWDATA),
        .HREADY       (HREADY),
        .HRESP        (HRESP),
        .HRDATA       (HRDATA)
    );

    always #5 kplic_clk = ~kplic_clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change at the falling edge, outputs are checked there too
    task automatic tick();
        @(posedge kplic_clk);
        @(negedge kplic_clk);
    endtask

    // Model: an ID-0 claim bumps the count (saturating) only in the counting build
    task automatic note_spurious();
`ifdef KPLIC_CLAIM_SPURIOUS_CNT_EN
        if (exp_spur != 16'hFFFF) exp_spur = exp_spur + 16'd1;
`endif
    endtask

    task automatic chk_reset_values(input string tag);
        chk_eq({tag, "_htrans"},  32'(HTRANS),       32'(T_IDLE));
        chk_eq({tag, "_haddr"},   HADDR,             32'h0);
        chk_eq({tag, "_hwrite"},  32'(HWRITE),       32'd0);
        chk_eq({tag, "_hwdata"},  HWDATA,            32'h0);
        chk_eq({tag, "_irq_id"},  32'(irq_id),       32'd0);
        chk_eq({tag, "_valid"},   32'(irq_valid),    32'd0);
        chk_eq({tag, "_bus_err"}, 32'(bus_err),      32'd0);
        chk_eq({tag, "_spur"},    32'(spurious_cnt), 32'd0);
    endtask

    // One complete claim transaction as seen from the bus slave and the core.
    // aw/dw/ww: HREADY-low cycles in claim address, claim data, completion data.
    // rw: cycles irq_ready is held low; gap: idle cycles before irq_done.
    task automatic do_claim(input logic [4:0] id, input bit rd_err, input int aw, input int dw,
                            input int rw, input bit early_done, input int gap,
                            input bit wr_err, input int ww, input bit hold_int, input bit rst_waddr);
        bit aborted = 1'b0;
        kplic_int = 1'b1; HREADY = 1'b1; HRESP = R_OKAY;
        tick();
        chk_eq("c_htrans", 32'(HTRANS), 32'(T_NONSEQ));
        chk_eq("c_haddr",  HADDR, CLAIM);
        chk_eq("c_hwrite", 32'(HWRITE), 32'd0);
        chk_eq("c_hsize",  32'(HSIZE), 32'd2);
        chk_eq("c_hburst", 32'(HBURST), 32'd0);
        if (!hold_int) kplic_int = 1'b0;
        for (int i = 0; i < aw; i++) begin
            HREADY = 1'b0; tick();
            chk_eq("c_hold_htrans", 32'(HTRANS), 32'(T_NONSEQ));
            chk_eq("c_hold_haddr",  HADDR, CLAIM);
        end
        HREADY = 1'b1; tick();
        chk_eq("c_data_htrans", 32'(HTRANS), 32'(T_IDLE));
        chk_eq("c_data_valid",  32'(irq_valid), 32'd0);
        for (int i = 0; i < dw; i++) begin
            HREADY = 1'b0; tick();
            chk_eq("c_wait_htrans", 32'(HTRANS), 32'(T_IDLE));
            chk_eq("c_wait_valid",  32'(irq_valid), 32'd0);
        end
        HREADY = 1'b1; HRESP = rd_err ? R_ERR : R_OKAY;
        HRDATA = $urandom; HRDATA[4:0] = id;
        tick();
        HRESP = R_OKAY; HRDATA = $urandom;
        if (rd_err) begin
            chk_eq("rd_bus_err", 32'(bus_err), 32'd1);
            chk_eq("rd_err_valid", 32'(irq_valid), 32'd0);
        end else if (id == 5'd0) begin
            note_spurious();
            chk_eq("spur_valid", 32'(irq_valid), 32'd0);
            chk_eq("spur_cnt_now", 32'(spurious_cnt), 32'(exp_spur));
        end else begin
            chk_eq("pres_valid", 32'(irq_valid), 32'd1);
            chk_eq("pres_id", 32'(irq_id), 32'(id));
            for (int i = 0; i < rw; i++) begin
                irq_ready = 1'b0; irq_done = early_done && (i == 0);
                tick();
                irq_done = 1'b0;
                chk_eq("pres_hold_valid", 32'(irq_valid), 32'd1);
                chk_eq("pres_hold_id", 32'(irq_id), 32'(id));
                chk_eq("pres_hold_htrans", 32'(HTRANS), 32'(T_IDLE));
            end
            irq_ready = 1'b1; tick(); irq_ready = 1'b0;
            chk_eq("acc_valid", 32'(irq_valid), 32'd0);
            for (int i = 0; i < gap; i++) begin
                tick();
                chk_eq("act_htrans", 32'(HTRANS), 32'(T_IDLE));
            end
            irq_done = 1'b1; tick(); irq_done = 1'b0;
            chk_eq("w_htrans", 32'(HTRANS), 32'(T_NONSEQ));
            chk_eq("w_hwrite", 32'(HWRITE), 32'd1);
            chk_eq("w_haddr",  HADDR, CLAIM);
            if (rst_waddr) begin
                #2 kplic_rst = 1'b1;
                #1 chk_reset_values("rst");
                @(negedge kplic_clk);
                kplic_rst = 1'b0;
                kplic_int = 1'b0;
                exp_spur = 16'h0;
                aborted = 1'b1;
            end else begin
                tick();
                chk_eq("wd_htrans", 32'(HTRANS), 32'(T_IDLE));
                chk_eq("wd_hwdata", HWDATA, {27'b0, id});
                for (int i = 0; i < ww; i++) begin
                    HREADY = 1'b0; tick();
                    chk_eq("wd_hold_hwdata", HWDATA, {27'b0, id});
                    chk_eq("wd_hold_htrans", 32'(HTRANS), 32'(T_IDLE));
                end
                HREADY = 1'b1; HRESP = wr_err ? R_ERR : R_OKAY;
                tick();
                HRESP = R_OKAY;
                chk_eq("wr_bus_err", 32'(bus_err), 32'(wr_err));
            end
        end
        if (!aborted) begin
            // Back in IDLE: a still-high kplic_int starts a new claim at once
            tick();
            chk_eq("end_bus_err", 32'(bus_err), 32'd0);
            chk_eq("end_htrans", 32'(HTRANS), hold_int ? 32'(T_NONSEQ) : 32'(T_IDLE));
            if (hold_int) begin
                kplic_int = 1'b0; HREADY = 1'b1; tick();
                HRDATA = $urandom; HRDATA[4:0] = 5'd0;
                tick();
                HRDATA = $urandom;
                note_spurious();
                chk_eq("stale_valid", 32'(irq_valid), 32'd0);
            end
            chk_eq("spur_cnt", 32'(spurious_cnt), 32'(exp_spur));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        kplic_rst = 1'b1; kplic_int = 1'b0; irq_ready = 1'b0; irq_done = 1'b0;
        HREADY = 1'b1; HRESP = R_OKAY; HRDATA = 32'h0;
        repeat (2) @(negedge kplic_clk);
        chk_reset_values("por");
        kplic_rst = 1'b0;
        tick();

        // id  rderr aw dw rw early gap wrerr ww hold rst
        do_claim(5'd7,  0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        do_claim(5'd0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        do_claim(5'd21, 0, 4, 0, 0,  0, 1, 0, 4, 0, 0);
        do_claim(5'd5,  1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        do_claim(5'd12, 0, 0, 0, 10, 1, 2, 0, 0, 0, 0);
        do_claim(5'd9,  0, 0, 1, 0,  0, 0, 1, 1, 1, 0);
        do_claim(5'd30, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        do_claim(5'd3,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [4:0] id;
            bit rd_err, hold, rst_w;
            id     = 5'($urandom_range(0, 31));
            rd_err = ($urandom_range(0, 7) == 0);
            hold   = ($urandom_range(0, 5) == 0);
            rst_w  = !hold && ($urandom_range(0, 9) == 0);
            do_claim(id, rd_err, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                     ($urandom_range(0, 7) == 0), $urandom_range(0, 3), hold, rst_w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
